fp16_mul_norm_round: RTL and testbench

- Downstream stage of the fp16 multiplier datapath.
- Consumes the 22-bit product of two 11-bit mantissas (hidden bit included), the result sign, the raw exponent sum and special-case flags.
- Produces a packed IEEE fp16 result: normalized, round-to-nearest-even, flush-to-zero.
- Two-stage valid/ready pipeline, so systolic PEs can stall it without losing data.

---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_round_pack.sv | 52 +++++
 rtl/fp16_mul_norm_round.sv | 104 ++++++++++
 tb/tb_fp16_mul_norm_round.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the multiplier datapath: format constants,
// the packed fp16 word and the normalize-stage register layout.
package fp16_pkg;

  localparam int          FP16_EXP_BIAS = 15;
  localparam int          FP16_EXP_MAX  = 31;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  // e is the unbiased-then-rebiased result exponent before rounding; it can
  // go negative or far above the fp16 range, hence the signed 8-bit field.
  typedef struct packed {
    logic              sign;
    logic [9:0]        frac;
    logic              guard;
    logic              sticky;
    logic signed [7:0] e;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } norm_stage_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Stage-2 combinational logic: round-to-nearest-even on the normalized
// fraction, then resolve specials, overflow and flush-to-zero into fp16.
module fp16_round_pack
  import fp16_pkg::*;
#(
  parameter logic [15:0] NAN_PATTERN = FP16_QNAN
) (
  input  norm_stage_t norm,
  output fp16_t       result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic signed [8:0] E_MAX = 9'(FP16_EXP_MAX);

  logic              round_up;
  logic [10:0]       frac_sum;
  logic signed [8:0] e_r;

  always_comb begin
    round_up  = norm.guard & (norm.sticky | norm.frac[0]);
    frac_sum  = {1'b0, norm.frac} + {10'b0, round_up};
    // A carry out of the fraction bumps the exponent; the fraction wraps to 0.
    e_r       = {norm.e[7], norm.e} + {8'b0, frac_sum[10]};

    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = 1'b0;

    if (norm.is_nan) begin
      result = NAN_PATTERN;
    end else if (norm.is_inf) begin
      result = {norm.sign, 5'h1F, 10'h0};
    end else if (norm.is_zero) begin
      result = {norm.sign, 15'h0};
    end else if (e_r >= E_MAX) begin
      result   = {norm.sign, 5'h1F, 10'h0};
      overflow = 1'b1;
      inexact  = 1'b1;
    end else if (e_r <= 9'sd0) begin
      result    = {norm.sign, 15'h0};
      underflow = 1'b1;
      inexact   = 1'b1;
    end else begin
      result  = {norm.sign, e_r[4:0], frac_sum[9:0]};
      inexact = norm.guard | norm.sticky;
    end
  end

endmodule

// File: rtl/fp16_mul_norm_round.sv
// Normalize / round / pack back end of the fp16 multiplier: a two-entry
// valid/ready pipeline (normalize register, then packed result register).
module fp16_mul_norm_round
  import fp16_pkg::*;
#(
  parameter int          EXP_BIAS    = FP16_EXP_BIAS,
  parameter logic [15:0] NAN_PATTERN = FP16_QNAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [5:0]  in_exp_sum,
  input  logic [21:0] in_mant_prod,
  input  logic        in_is_zero,
  input  logic        in_is_inf,
  input  logic        in_is_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  // Handshake: a word moves across a boundary on a rising edge where the
  // sender's valid and the receiver's ready are both high. Valid never drops
  // and payload never changes while waiting for ready. Ready is combinational
  // from the downstream stage (no skid buffer), so each stage holds one entry.

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  norm_stage_t s1_d;
  norm_stage_t s1_q;
  fp16_t       rp_result;
  logic        rp_overflow;
  logic        rp_underflow;
  logic        rp_inexact;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  // Product of two [1,2) significands lies in [1,4): bit 21 selects the shift.
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = in_sign;
    s1_d.is_zero = in_is_zero;
    s1_d.is_inf  = in_is_inf;
    s1_d.is_nan  = in_is_nan;
    s1_d.e       = {2'b00, in_exp_sum} - 8'(EXP_BIAS) + {7'b0, in_mant_prod[21]};
    if (in_mant_prod[21]) begin
      s1_d.frac   = in_mant_prod[20:11];
      s1_d.guard  = in_mant_prod[10];
      s1_d.sticky = |in_mant_prod[9:0];
    end else begin
      s1_d.frac   = in_mant_prod[19:10];
      s1_d.guard  = in_mant_prod[9];
      s1_d.sticky = |in_mant_prod[8:0];
    end
  end

  fp16_round_pack #(
    .NAN_PATTERN (NAN_PATTERN)
  ) u_round_pack (
    .norm      (s1_q),
    .result    (rp_result),
    .overflow  (rp_overflow),
    .underflow (rp_underflow),
    .inexact   (rp_inexact)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s1_q          <= '0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_q <= s1_d;
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
      end
      // Output payload only changes when a new entry actually enters stage 2.
      if (s1_adv && s1_valid) begin
        out_result    <= rp_result;
        out_overflow  <= rp_overflow;
        out_underflow <= rp_underflow;
        out_inexact   <= rp_inexact;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_norm_round.sv
// Scoreboard bench for fp16_mul_norm_round: directed corner vectors,
// backpressure and reset-under-stall scenarios, then randomized traffic.
module tb_fp16_mul_norm_round;

  typedef struct {
    logic        s;
    logic [5:0]  e;
    logic [21:0] p;
    logic        z;
    logic        i;
    logic        n;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp_sum;
  logic [21:0] in_mant_prod;
  logic        in_is_zero;
  logic        in_is_inf;
  logic        in_is_nan;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  logic [18:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  int          n_out;
  int          cyc;
  int          acc_cyc;
  int          last_out_cyc;
  logic        rand_rdy;
  logic        hold_v;
  logic [18:0] hold_d;

  fp16_mul_norm_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp_sum    (in_exp_sum),
    .in_mant_prod  (in_mant_prod),
    .in_is_zero    (in_is_zero),
    .in_is_inf     (in_is_inf),
    .in_is_nan     (in_is_nan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [5:0] e, input logic [21:0] p,
                              input logic z, input logic i, input logic n);
    vec_t v;
    v.s = s; v.e = e; v.p = p; v.z = z; v.i = i; v.n = n;
    return v;
  endfunction

  // Reference: treat the product as an integer significand, keep the top 11
  // bits, compare the discarded remainder against one half ulp.
  function automatic logic [18:0] model(input vec_t v);
    int pi, msb, sh, sig, rem, half, e;
    logic inx;
    if (v.n) return {16'h7E00, 3'b000};
    if (v.i) return {v.s, 5'h1F, 10'h0, 3'b000};
    if (v.z) return {v.s, 15'h0, 3'b000};
    pi   = int'(v.p);
    msb  = (pi >= (1 << 21)) ? 21 : 20;
    sh   = msb - 10;
    sig  = pi >> sh;
    rem  = pi & ((1 << sh) - 1);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
    e = int'(v.e) - 15 + (msb - 20);
    if (sig == 2048) begin
      sig = 1024;
      e++;
    end
    inx = (rem != 0);
    if (e >= 31) return {v.s, 5'h1F, 10'h0, 3'b101};
    if (e <= 0)  return {v.s, 15'h0, 3'b011};
    return {v.s, 5'(e), 10'(sig), 2'b00, inx};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   ma, mb, sel;
    ma  = 1024 + $urandom_range(0, 1023);
    mb  = 1024 + $urandom_range(0, 1023);
    v.s = 1'($urandom_range(0, 1));
    v.e = 6'($urandom_range(0, 60));
    v.p = 22'(ma * mb);
    sel = $urandom_range(0, 19);
    v.z = (sel == 0);
    v.i = (sel == 1) || (sel == 3);
    v.n = (sel == 2) || (sel == 3);
    if (sel == 4) v.p = {11'h400 | 11'($urandom_range(0, 1023)), 11'h400} >> 1;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v, input logic [18:0] exp);
    int t;
    t = 0;
    in_valid     = 1'b1;
    in_sign      = v.s;
    in_exp_sum   = v.e;
    in_mant_prod = v.p;
    in_is_zero   = v.z;
    in_is_inf    = v.i;
    in_is_nan    = v.n;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_outputs(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("out_count", 32'(n_out), 32'(target));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        check("hold_stable", {12'b0, out_valid, out_result, out_overflow, out_underflow, out_inexact},
              {12'b0, 1'b1, hold_d});
      if (out_valid && out_ready) begin
        hold_v = 1'b0;
        n_out++;
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %h expected no output", out_result);
        end else begin
          check("result", {13'b0, out_result, out_overflow, out_underflow, out_inexact},
                {13'b0, exp_q.pop_front()});
        end
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_d = {out_result, out_overflow, out_underflow, out_inexact};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  vec_t        dir_v[16];
  logic [18:0] dir_e[16];

  initial begin
    vec_t bp[4];
    vec_t rv;
    int   idx, n_before, t;

    n_cmp = 0; n_err = 0; n_out = 0; cyc = 0; acc_cyc = 0; last_out_cyc = 0;
    rand_rdy = 1'b0; hold_v = 1'b0; hold_d = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp_sum = '0; in_mant_prod = '0;
    in_is_zero = 1'b0; in_is_inf = 1'b0; in_is_nan = 1'b0;

    dir_v[0]  = mk(0, 30, 22'h100000, 0, 0, 0); dir_e[0]  = {16'h3C00, 3'b000};
    dir_v[1]  = mk(0, 30, 22'h240000, 0, 0, 0); dir_e[1]  = {16'h4080, 3'b000};
    dir_v[2]  = mk(0, 30, 22'h100200, 0, 0, 0); dir_e[2]  = {16'h3C00, 3'b001};
    dir_v[3]  = mk(0, 30, 22'h100600, 0, 0, 0); dir_e[3]  = {16'h3C02, 3'b001};
    dir_v[4]  = mk(0, 30, 22'h1FFE00, 0, 0, 0); dir_e[4]  = {16'h4000, 3'b001};
    dir_v[5]  = mk(0, 60, 22'h100000, 0, 0, 0); dir_e[5]  = {16'h7C00, 3'b101};
    dir_v[6]  = mk(1, 10, 22'h100000, 0, 0, 0); dir_e[6]  = {16'h8000, 3'b011};
    dir_v[7]  = mk(1, 30, 22'h100000, 0, 1, 1); dir_e[7]  = {16'h7E00, 3'b000};
    dir_v[8]  = mk(1, 30, 22'h100000, 0, 1, 0); dir_e[8]  = {16'hFC00, 3'b000};
    dir_v[9]  = mk(1, 30, 22'h100000, 1, 0, 0); dir_e[9]  = {16'h8000, 3'b000};
    dir_v[10] = mk(0, 45, 22'h100000, 0, 0, 0); dir_e[10] = {16'h7800, 3'b000};
    dir_v[11] = mk(0, 45, 22'h1FFE00, 0, 0, 0); dir_e[11] = {16'h7C00, 3'b101};
    dir_v[12] = mk(0, 15, 22'h1FFE00, 0, 0, 0); dir_e[12] = {16'h0400, 3'b001};
    dir_v[13] = mk(0, 16, 22'h100000, 0, 0, 0); dir_e[13] = {16'h0400, 3'b000};
    dir_v[14] = mk(0, 15, 22'h100000, 0, 0, 0); dir_e[14] = {16'h0000, 3'b011};
    dir_v[15] = mk(1, 30, 22'h3FFFFF, 0, 0, 0); dir_e[15] = {16'hC400, 3'b001};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", {16'b0, out_result}, 32'd0);
    check("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
    rst_n = 1'b1;

    // Latency from an empty pipe
    send(dir_v[0], dir_e[0]);
    wait_outputs(1);
    check("latency", 32'(last_out_cyc - acc_cyc), 32'd2);

    // Directed corners, back to back
    for (int k = 1; k < 16; k++) send(dir_v[k], dir_e[k]);
    wait_outputs(16);

    // Backpressure: 4 offered while stalled, only 2 fit
    for (int k = 0; k < 4; k++) bp[k] = rand_vec();
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_sign = bp[0].s; in_exp_sum = bp[0].e; in_mant_prod = bp[0].p;
    in_is_zero = bp[0].z; in_is_inf = bp[0].i; in_is_nan = bp[0].n;
    repeat (5) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp[idx]));
        idx++;
      end
      @(posedge clk);
      #1;
      in_sign = bp[idx].s; in_exp_sum = bp[idx].e; in_mant_prod = bp[idx].p;
      in_is_zero = bp[idx].z; in_is_inf = bp[idx].i; in_is_nan = bp[idx].n;
    end
    check("stall_accepted", 32'(idx), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    while (idx < 4) begin
      send(bp[idx], model(bp[idx]));
      idx++;
    end
    wait_outputs(20);

    // Reset while both stages are full and stalled
    out_ready = 1'b0;
    rv = rand_vec(); send(rv, model(rv));
    rv = rand_vec(); send(rv, model(rv));
    repeat (2) @(posedge clk);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    n_before = n_out;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_ghosts", 32'(n_out), 32'(n_before));

    // Randomized traffic with random downstream stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rv = rand_vec();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(rv, model(rv));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
